// File: rtl/ahb_spi_pkg.sv
// ahb_spi_pkg: shared constants and FSM state type for the AHB-to-SPI
// bridge arbiter.
//   HTRANS_IDLE / HTRANS_NONSEQ : AHB-Lite transfer type encodings
//   HSIZE_WORD / HBURST_SINGLE  : the only size/burst this master issues
//   arb_state_e                 : arbiter FSM states
package ahb_spi_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ahb_spi_rr_pick.sv
// ahb_spi_rr_pick: combinational round-robin picker.
//   req    [NREQ-1:0] : request vector
//   last   [IDXW-1:0] : index of the previous winner
//   winner [NREQ-1:0] : one-hot winner, search starts at last+1 and wraps
//   valid             : at least one request is present
module ahb_spi_rr_pick #(
  parameter int NREQ = 3,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] back;
  logic [NREQ-1:0]   rot_lo;
  logic [NREQ-1:0]   pick_rot;
  logic [IDXW:0]     shamt;

  // Rotate so that index last+1 sits at bit 0, take the lowest set bit,
  // then rotate the one-hot result back into requester order.
  always_comb begin
    shamt    = {1'b0, last} + (IDXW+1)'(1);
    dbl      = {req, req};
    rot_lo   = NREQ'(dbl >> shamt);
    pick_rot = rot_lo & ~(rot_lo - NREQ'(1));
    back     = {pick_rot, pick_rot} << shamt;
    winner   = NREQ'(back >> NREQ);
    valid    = |req;
  end

endmodule

// File: rtl/ahb_spi_arbiter.sv
// ahb_spi_arbiter: round-robin arbiter letting NREQ requesters share one
// AHB-Lite master port into an AHB-to-SPI bridge, one single-beat transfer
// at a time.
//   HCLK, HRESET (async, active low)
//   req/req_addr/req_write/req_wdata : per-requester transfer requests
//   gnt/done/err/rdata               : per-requester grant and completion
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA : AHB-Lite master outputs
//   HRDATA/HREADY/HRESP              : AHB-Lite slave response
//   dbg_state                        : current FSM state
// Optional: define AHB_SPI_ARB_TIMEOUT_EN to abort a data phase after
// TIMEOUT_CYCLES consecutive HREADY=0 cycles, completing it with err=1.
//
// Handshake: req[i] is a level held until done[i] pulses for one cycle;
// the requester's addr/write/wdata are latched when it is granted, so
// only req must stay stable. Dropping req mid-transfer does not cancel
// it. err[i] and rdata are meaningful only in the done[i] cycle.
module ahb_spi_arbiter
  import ahb_spi_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*8-1:0]  req_addr,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [31:0]        rdata,
  output logic [7:0]         HADDR,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [2:0]         HSIZE,
  output logic [2:0]         HBURST,
  output logic [31:0]        HWDATA,
  input  logic [31:0]        HRDATA,
  input  logic               HREADY,
  input  logic               HRESP,
  output arb_state_e         dbg_state
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] owner_q;
  logic [IDXW-1:0] owner_idx_q;
  logic [IDXW-1:0] last_q;
  logic [7:0]      addr_q;
  logic            write_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [NREQ-1:0] pick_win;
  logic            pick_valid;
  logic [IDXW-1:0] sel_idx;
  logic [7:0]      sel_addr;
  logic            sel_write;
  logic [31:0]     sel_wdata;
  logic            timeout_hit;

  ahb_spi_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  // Mux the winner's request fields out of the packed vectors.
  always_comb begin
    sel_idx   = '0;
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win[i]) begin
        sel_idx   = IDXW'(i);
        sel_addr  = req_addr[8*i +: 8];
        sel_write = req_write[i];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

`ifdef AHB_SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;

  // Counts consecutive stalled data-phase cycles; fires on the last one.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      to_cnt_q <= '0;
    end else if (state_q != ST_DATA || HREADY) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end
  end

  assign timeout_hit = !HREADY && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      owner_idx_q <= '0;
      last_q      <= IDXW'(NREQ - 1);
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_q     <= pick_win;
            owner_idx_q <= sel_idx;
            addr_q      <= sel_addr;
            write_q     <= sel_write;
            wdata_q     <= sel_wdata;
            err_q       <= 1'b0;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            rdata_q <= HRDATA;
            err_q   <= HRESP;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        ST_DONE: begin
          last_q  <= owner_idx_q;
          owner_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    HTRANS  = HTRANS_IDLE;
    HADDR   = '0;
    HWRITE  = 1'b0;
    HSIZE   = '0;
    HBURST  = HBURST_SINGLE;
    HWDATA  = '0;
    done    = '0;
    err     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = addr_q;
        HWRITE = write_q;
        HSIZE  = HSIZE_WORD;
        if (HREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        HWDATA = wdata_q;
        if (HREADY || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = owner_q;
        err     = err_q ? owner_q : '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt       = owner_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_spi_arbiter.sv
// tb_ahb_spi_arbiter: directed and randomized checks of ahb_spi_arbiter
// against a transaction-level model (round-robin order from the last
// winner, expected AHB phases, completion latency and response data).
module tb_ahb_spi_arbiter;
  import ahb_spi_pkg::*;

  localparam int NREQ = 3;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESET = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [NREQ-1:0]    req;
  logic [NREQ*8-1:0]  req_addr;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, done, err;
  logic [31:0]        rdata;
  logic [7:0]         HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HSIZE, HBURST;
  logic [31:0]        HWDATA;
  logic [31:0]        HRDATA;
  logic               HREADY, HRESP;
  arb_state_e         dbg_state;

  ahb_spi_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req(req), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  int last_w = NREQ - 1;
  logic [31:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  function automatic int next_winner(input logic [NREQ-1:0] m);
    logic [NREQ-1:0] sh;
    for (int k = 1; k <= NREQ; k++) begin
      sh = m >> ((last_w + k) % NREQ);
      if (sh[0]) return (last_w + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    HRESET = 1'b0;
    req = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    step();
    step();
    HRESET = 1'b1;
    last_w = NREQ - 1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic w, input logic [31:0] d);
    req_addr[8*i +: 8]   = a;
    req_write[i]         = w;
    req_wdata[32*i +: 32] = d;
    req[i]               = 1'b1;
  endtask

  // Runs one transaction from IDLE; returns the granted index.
  task automatic do_txn(input string name, input int aw, input int dw,
                        input logic [31:0] rd, input logic resp,
                        input bit drop_mid, input bit release_after,
                        output int w);
    logic [NREQ-1:0] oh;
    logic [7:0]      e_addr;
    logic            e_write;
    logic [31:0]     e_wdata;
    logic [31:0]     exp_rd;
    int lat;
    w = next_winner(req);
    checks++;
    if (w < 0) begin
      errors++;
      $display("FAIL %s: no request pending, req=%b", name, req);
      return;
    end
    oh      = NREQ'(1) << w;
    e_addr  = req_addr[8*w +: 8];
    e_write = req_write[w];
    e_wdata = req_wdata[32*w +: 32];
    if (!e_write && !resp) exp_q.push_back(rd);
    lat = 0;
    step(); lat++;
    // Fields must have been latched at grant: scramble the inputs now.
    req_addr  = {NREQ{8'($urandom())}};
    req_wdata = {NREQ{$urandom()}};
    req_write = NREQ'($urandom());
    for (int k = 0; k <= aw; k++) begin
      checks++;
      if (gnt !== oh || HTRANS !== 2'b10 || HADDR !== e_addr || HWRITE !== e_write ||
          HSIZE !== 3'b010 || HBURST !== 3'b000 || done !== '0) begin
        errors++;
        $display("FAIL %s addr phase: gnt=%b HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%b HBURST=%b done=%b, want gnt=%b HTRANS=10 HADDR=%h HWRITE=%b HSIZE=010 HBURST=000 done=0",
                 name, gnt, HTRANS, HADDR, HWRITE, HSIZE, HBURST, done, oh, e_addr, e_write);
      end
      HREADY = (k == aw);
      step(); lat++;
    end
    for (int k = 0; k <= dw; k++) begin
      if (drop_mid && k == 0) req[w] = 1'b0;
      checks++;
      if (gnt !== oh || HTRANS !== 2'b00 || (e_write && HWDATA !== e_wdata) || done !== '0) begin
        errors++;
        $display("FAIL %s data phase: gnt=%b HTRANS=%b HWDATA=%h done=%b, want gnt=%b HTRANS=00 HWDATA=%h done=0",
                 name, gnt, HTRANS, HWDATA, done, oh, e_wdata);
      end
      HREADY = (k == dw);
      HRDATA = (k == dw) ? rd : $urandom();
      HRESP  = (k == dw) ? resp : 1'b0;
      step(); lat++;
    end
    checks++;
    if (done !== oh || gnt !== oh || err !== (resp ? oh : NREQ'(0))) begin
      errors++;
      $display("FAIL %s done cycle: done=%b gnt=%b err=%b, want done=%b gnt=%b err=%b",
               name, done, gnt, err, oh, oh, resp ? oh : NREQ'(0));
    end
    if (!e_write && !resp) begin
      exp_rd = exp_q.pop_front();
      checks++;
      if (rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rd);
      end
    end
    checks++;
    if (lat != 3 + aw + dw) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, 3 + aw + dw);
    end
    last_w = w;
    if (release_after) req[w] = 1'b0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    step();
    checks++;
    if (done !== '0 || gnt !== '0 || HTRANS !== 2'b00) begin
      errors++;
      $display("FAIL %s idle gap: done=%b gnt=%b HTRANS=%b, want all 0", name, done, gnt, HTRANS);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    HRESET = 1'b0;
    req = '1; req_addr = '1; req_write = '1; req_wdata = '1;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '1;
    step();
    step();
    checks++;
    if (gnt !== '0 || done !== '0 || err !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset outputs: gnt=%b done=%b err=%b rdata=%h, want 0", gnt, done, err, rdata);
    end
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== '0 || HWDATA !== '0 || HWRITE !== 1'b0 ||
        HSIZE !== '0 || HBURST !== '0) begin
      errors++;
      $display("FAIL reset ahb: HTRANS=%b HADDR=%h HWDATA=%h HWRITE=%b HSIZE=%b HBURST=%b, want 0",
               HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST);
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    int w;
    apply_reset();
    set_req(0, 8'h10, 1'b1, 32'hA5A5_0001);
    do_txn("single_write", 0, 0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL single_write winner: got %0d want 0", w);
    end
  endtask

  task automatic test_contention();
    int w;
    int exp_order[4] = '{0, 1, 2, 0};
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h20 + i), 1'b1, 32'h1000 + i);
    for (int t = 0; t < 4; t++) begin
      do_txn("contention", 0, 0, 32'h0, 1'b0, 1'b0, 1'b0, w);
      checks++;
      if (w != exp_order[t]) begin
        errors++;
        $display("FAIL contention order[%0d]: got %0d want %0d", t, w, exp_order[t]);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_wait_states();
    int w;
    set_req(1, 8'h04, 1'b0, 32'h0);
    do_txn("wait_read", 0, 5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL wait_read winner: got %0d want 1", w);
    end
  endtask

  task automatic test_error();
    int w;
    set_req(2, 8'h30, 1'b0, 32'h0);
    do_txn("error_resp", 1, 1, 32'h1234_5678, 1'b1, 1'b0, 1'b1, w);
    checks++;
    if (w != 2) begin
      errors++;
      $display("FAIL error_resp winner: got %0d want 2", w);
    end
  endtask

  task automatic test_reset_in_data();
    int w;
    apply_reset();
    set_req(1, 8'h44, 1'b1, 32'h5555_AAAA);
    step();
    step();
    HREADY = 1'b0;
    #2 HRESET = 1'b0;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || gnt !== '0 || done !== '0) begin
      errors++;
      $display("FAIL reset_in_data async: HTRANS=%b gnt=%b done=%b, want 0", HTRANS, gnt, done);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (done !== '0 || gnt !== '0) begin
        errors++;
        $display("FAIL reset_in_data held: done=%b gnt=%b, want 0", done, gnt);
      end
    end
    HREADY = 1'b1;
    HRESET = 1'b1;
    last_w = NREQ - 1;
    do_txn("after_reset", 0, 0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL after_reset winner: got %0d want 1", w);
    end
  endtask

  task automatic test_random();
    int w;
    for (int t = 0; t < 40; t++) begin
      logic [NREQ-1:0] add;
      add = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        if (add[i] && !req[i]) set_req(i, 8'($urandom()), 1'($urandom()), $urandom());
      end
      do_txn("random", $urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'b1, w);
    end
    req = '0;
    step();
  endtask

`ifdef AHB_SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    set_req(0, 8'h50, 1'b0, 32'h0);
    step();
    step();
    HREADY = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (done !== '0 || HTRANS !== 2'b00) begin
        errors++;
        $display("FAIL timeout early: cycle %0d done=%b HTRANS=%b, want done=0 HTRANS=00", k, done, HTRANS);
      end
      step();
    end
    step();
    checks++;
    if (done !== 3'b001 || err !== 3'b001 || HTRANS !== 2'b00) begin
      errors++;
      $display("FAIL timeout done: done=%b err=%b HTRANS=%b, want 001 001 00", done, err, HTRANS);
    end
    req = '0;
    HREADY = 1'b1;
    step();
    checks++;
    if (gnt !== '0 || done !== '0) begin
      errors++;
      $display("FAIL timeout idle: gnt=%b done=%b, want 0", gnt, done);
    end
    last_w = 0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_wait_states();
    test_error();
    test_reset_in_data();
    test_random();
`ifdef AHB_SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_spi_arbiter.md
AHB_SPI_ARBITER -- requirements
Module: ahb_spi_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the AHB-to-SPI bridge.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: data-phase wait limit in HCLK cycles (used only under REQ-027).
REQ-003 HCLK  input  1  single clock for all logic.
REQ-004 HRESET  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester transfer request, level, held until done.
REQ-006 req_addr  input  NREQ*8  packed addresses, requester i at bits [8i+7:8i].
REQ-007 req_write  input  NREQ  1 = write, 0 = read, per requester.
REQ-008 req_wdata  input  NREQ*32  packed write data, requester i at bits [32i+31:32i].
REQ-009 gnt  output  NREQ  one-hot owner of the bridge, 0 when idle.
REQ-010 done  output  NREQ  one-cycle completion pulse to the owner.
REQ-011 err  output  NREQ  error flag, valid only with done.
REQ-012 rdata  output  32  read data, valid only with done on a read.
REQ-013 HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA  output  8/2/1/3/3/32  AHB-Lite master signals to the bridge.
REQ-014 HRDATA/HREADY/HRESP  input  32/1/1  AHB-Lite slave response from the bridge.

Function
REQ-015 FSM states: IDLE, ADDR, DATA, DONE.
REQ-016 IDLE: when any req bit is 1, the arbiter SHALL pick a winner round-robin, starting the search at the index after the last winner, and enter ADDR on the next edge.
REQ-017 The winner's addr, write and wdata SHALL be latched on entry to ADDR, and gnt SHALL assert from ADDR through DONE inclusive.
REQ-018 ADDR: HTRANS=2'b10, HADDR=latched addr, HWRITE=latched write, HSIZE=3'b010, HBURST=3'b000; go to DATA on the first edge with HREADY=1.
REQ-019 DATA: HTRANS=2'b00, HWDATA=latched wdata; on the first edge with HREADY=1, capture HRDATA into rdata and HRESP into err, then go to DONE.
REQ-020 DONE: assert done for exactly one cycle, update the last-winner pointer, then return to IDLE.
REQ-021 Minimum latency from req seen in IDLE to done: 3 cycles with HREADY held 1.
REQ-022 Requests arriving together: lowest index first after reset, rotating thereafter; no requester waits more than NREQ transactions.
REQ-023 If req deasserts mid-transaction, the transaction SHALL complete and done SHALL still pulse.
REQ-024 HRESP=1 with HREADY=1 SHALL produce done together with err=1; rdata is then undefined.

Reset
REQ-025 While HRESET=0: state=IDLE, HTRANS=2'b00, HADDR/HWDATA/HWRITE/HSIZE/HBURST=0, gnt/done/err=0, rdata=0, last-winner pointer=NREQ-1.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately with no done pulse; arbitration SHALL restart from IDLE after release.

Configuration
REQ-027 With AHB_SPI_ARB_TIMEOUT_EN defined, a counter SHALL run in DATA. If HREADY stays 0 for TIMEOUT_CYCLES consecutive cycles, the FSM SHALL go to DONE with err=1 and HTRANS=2'b00.
REQ-028 Without AHB_SPI_ARB_TIMEOUT_EN, DATA SHALL wait on HREADY indefinitely and no counter logic SHALL exist.

Structure
REQ-029 Package ahb_spi_pkg SHALL hold the HTRANS constants (IDLE, NONSEQ), HSIZE_WORD, HBURST_SINGLE and the FSM state enum.
REQ-030 Sub-module ahb_spi_rr_pick SHALL be a combinational round-robin picker: inputs req and last pointer, outputs one-hot winner and valid.

Verification
REQ-031 Single write: req[0]=1, addr=8'h10, wdata=32'hA5A5_0001, HREADY=1 -> HTRANS=10 for one cycle, HWDATA=32'hA5A5_0001 in the next cycle, done[0] 3 cycles after req, err=0.
REQ-032 Contention: req=3'b111 held -> grant order 0,1,2,0, each gnt one-hot, no overlap.
REQ-033 Wait states: read from addr 8'h04, HREADY=0 for 5 DATA cycles, HRDATA=32'hDEAD_BEEF -> done[1] after the wait, rdata=32'hDEAD_BEEF.
REQ-034 Error: HRESP=1 with HREADY=1 in DATA -> done[2]=1 and err[2]=1 in the same cycle.
REQ-035 Reset in DATA: HRESET=0 -> HTRANS=00, gnt=0 asynchronously; no done; after release, req[1] is granted first.
REQ-036 Timeout (macro defined, TIMEOUT_CYCLES=8): HREADY held 0 in DATA -> done and err asserted after 8 cycles; FSM back in IDLE.
